gpdi_timing_ctrl: RTL

Video timing sequencer that drives the GPDI/TMDS output path. It generates raster counters, HS, VS and DE. It issues pixel fetch requests a fixed number of cycles ahead of active video to an upstream pixel source (framebuffer or line buffer). It re-times the returned pixels onto the `I_rgb_*` inputs of the TMDS encoders, blanks missing pixels and flags the underflow. It is the only block that writes the encoder inputs and runs in the pixel clock domain.

---
 rtl/gpdi_timing_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/gpdi_timing_ctrl.sv
// Raster timing sequencer for the GPDI/TMDS path: issues pixel fetches FETCH_LEAD cycles
// ahead of active video and re-times the returned pixels, syncs and DE onto the encoder inputs.
module gpdi_timing_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int FETCH_LEAD = 2
) (
    input  logic        I_pix_clk,
    input  logic        I_rst,
    input  logic        I_enable,
    input  logic        I_pix_valid,
    input  logic [7:0]  I_pix_r,
    input  logic [7:0]  I_pix_g,
    input  logic [7:0]  I_pix_b,
    input  logic        I_clr_underflow,
    output logic        O_pix_req,
    output logic [11:0] O_x,
    output logic [11:0] O_y,
    output logic        O_frame_start,
    output logic        O_rgb_hs,
    output logic        O_rgb_vs,
    output logic        O_rgb_de,
    output logic [7:0]  O_rgb_r,
    output logic [7:0]  O_rgb_g,
    output logic [7:0]  O_rgb_b,
    output logic        O_underflow,
    output logic        O_busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        issue;
    logic [11:0] hc;
    logic [11:0] vc;
    logic        last_pix;
    logic        act_c;
    logic        hs_c;
    logic        vs_c;
    logic        cap;
    logic        busy_c;

    // Stage 0 is the request stage; stage FETCH_LEAD drives the encoders.
    logic de_p  [0:FETCH_LEAD];
    logic hs_p  [0:FETCH_LEAD];
    logic vs_p  [0:FETCH_LEAD];
    logic vld_p [0:FETCH_LEAD-1];

    assign last_pix = (hc == H_LAST) && (vc == V_LAST);
    assign act_c    = ({1'b0, hc} < H_ACT_END) && ({1'b0, vc} < V_ACT_END);
    assign hs_c     = ({1'b0, hc} >= H_SYNC_BEG) && ({1'b0, hc} < H_SYNC_END);
    assign vs_c     = ({1'b0, vc} >= V_SYNC_BEG) && ({1'b0, vc} < V_SYNC_END);

    // A position is issued on every edge spent in RUN or DRAIN, plus the IDLE->RUN edge,
    // so the first RUN cycle already presents (0,0). Leaving the frame only happens on its last pixel.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (I_enable) begin
                    issue     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (!I_enable) state_nxt = last_pix ? IDLE : DRAIN;
            end
            DRAIN: begin
                issue = 1'b1;
                if (I_enable)      state_nxt = RUN;
                else if (last_pix) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            state <= IDLE;
            hc    <= '0;
            vc    <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? 12'd0 : vc + 12'd1;
                end else begin
                    hc <= hc + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            O_x           <= '0;
            O_y           <= '0;
            O_frame_start <= 1'b0;
            for (int k = 0; k <= FETCH_LEAD; k++) begin
                de_p[k] <= 1'b0;
                hs_p[k] <= 1'b0;
                vs_p[k] <= 1'b0;
            end
            for (int k = 0; k < FETCH_LEAD; k++) vld_p[k] <= 1'b0;
        end else begin
            O_x           <= issue ? hc : 12'd0;
            O_y           <= issue ? vc : 12'd0;
            O_frame_start <= issue && (hc == 12'd0) && (vc == 12'd0);
            de_p[0]       <= issue && act_c;
            hs_p[0]       <= issue && hs_c;
            vs_p[0]       <= issue && vs_c;
            vld_p[0]      <= issue;
            for (int k = 1; k <= FETCH_LEAD; k++) begin
                de_p[k] <= de_p[k-1];
                hs_p[k] <= hs_p[k-1];
                vs_p[k] <= vs_p[k-1];
            end
            for (int k = 1; k < FETCH_LEAD; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    // Capture edge: the edge that loads de=1 into the output stage.
    assign cap = de_p[FETCH_LEAD-1];

    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            O_rgb_r     <= '0;
            O_rgb_g     <= '0;
            O_rgb_b     <= '0;
            O_underflow <= 1'b0;
        end else begin
            if (cap && I_pix_valid) begin
                O_rgb_r <= I_pix_r;
                O_rgb_g <= I_pix_g;
                O_rgb_b <= I_pix_b;
            end else begin
                O_rgb_r <= '0;
                O_rgb_g <= '0;
                O_rgb_b <= '0;
            end
            if (cap && !I_pix_valid) O_underflow <= 1'b1;
            else if (I_clr_underflow) O_underflow <= 1'b0;
        end
    end

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < FETCH_LEAD; k++) busy_c = busy_c | vld_p[k];
    end

    assign O_pix_req = de_p[0];
    assign O_rgb_de  = de_p[FETCH_LEAD];
    assign O_rgb_hs  = hs_p[FETCH_LEAD] ? HS_POL : ~HS_POL;
    assign O_rgb_vs  = vs_p[FETCH_LEAD] ? VS_POL : ~VS_POL;
    assign O_busy    = busy_c;

endmodule
